// File: rtl/spi_pkg.sv
// Shared definitions for the SPI slave controller: FSM encoding, mode bit
// positions inside the latched mode vector, and legal word-width bounds.
package spi_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } spi_state_t;

  localparam int MODE_CPHA = 0;
  localparam int MODE_CPOL = 1;

  localparam int DATA_W_MIN = 4;
  localparam int DATA_W_MAX = 32;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for an asynchronous pin with single-cycle rise and
// fall pulses derived from the synchronised level.
module spi_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_p0;
  logic                   last_p1;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_p0 <= {SYNC_STAGES{RST_VAL}};
      last_p1 <= RST_VAL;
    end else begin
      sync_p0 <= {sync_p0[SYNC_STAGES-2:0], d_i};
      last_p1 <= sync_p0[SYNC_STAGES-1];
    end
  end

  // edge stage: compare settled level against its one-cycle-old copy
  assign rise_o = sync_p0[SYNC_STAGES-1] & ~last_p1;
  assign fall_o = ~sync_p0[SYNC_STAGES-1] & last_p1;

endmodule

// File: rtl/spi_slave_ctrl.sv
// Oversampled SPI slave (all CPOL/CPHA modes) with TX holding and RX output
// registers. Define SPI_SLAVE_STATUS_EN for sticky overrun/underrun flags.
module spi_slave_ctrl
  import spi_pkg::*;
#(
  parameter int                DATA_W      = 8,
  parameter int                SYNC_STAGES = 2,
  parameter logic [DATA_W-1:0] TX_FILL     = '0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cpol_i,
  input  logic              cpha_i,
  input  logic [DATA_W-1:0] tx_data_bi,
  input  logic              tx_load_i,
  output logic              tx_ready_o,
  output logic [DATA_W-1:0] rx_data_bo,
  output logic              rx_valid_o,
  input  logic              rx_ack_i,
  output logic              busy_o,
`ifdef SPI_SLAVE_STATUS_EN
  input  logic              status_clr_i,
  output logic              rx_overrun_o,
  output logic              tx_underrun_o,
`endif
  output logic              spi_miso_o,
  input  logic              spi_mosi_i,
  input  logic              spi_sclk_i,
  input  logic              spi_cs_i
);

  localparam int                CNT_W    = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DATA_W - 1);

  if (DATA_W < DATA_W_MIN || DATA_W > DATA_W_MAX) begin : g_bad_width
    $error("spi_slave_ctrl: DATA_W out of range");
  end

  spi_state_t        state, state_nxt;
  logic [1:0]        mode_q;
  logic [DATA_W-1:0] sr;
  logic [DATA_W-1:0] tx_hold;
  logic [CNT_W-1:0]  bit_cnt;
  logic              bit_buf, skip_first, reload_pend;
  logic              sclk_rise, sclk_fall, cs_rise, cs_fall;
  logic [SYNC_STAGES-1:0] mosi_sync_p0;
  logic              mosi_s, lead, trail, smp_edge, sft_edge;
  logic              start, smp, sft, complete, reload, consume, load_acc;
  logic [DATA_W-1:0] load_val;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
    .clk_i (clk_i), .rst_i (rst_i), .d_i (spi_sclk_i),
    .rise_o(sclk_rise), .fall_o(sclk_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
    .clk_i (clk_i), .rst_i (rst_i), .d_i (spi_cs_i),
    .rise_o(cs_rise), .fall_o(cs_fall)
  );

  // MOSI has the same depth as SCLK so it lines up with the detected edge
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) mosi_sync_p0 <= '0;
    else       mosi_sync_p0 <= {mosi_sync_p0[SYNC_STAGES-2:0], spi_mosi_i};
  end
  assign mosi_s = mosi_sync_p0[SYNC_STAGES-1];

  assign lead     = mode_q[MODE_CPOL] ? sclk_fall : sclk_rise;
  assign trail    = mode_q[MODE_CPOL] ? sclk_rise : sclk_fall;
  assign smp_edge = mode_q[MODE_CPHA] ? trail : lead;
  assign sft_edge = mode_q[MODE_CPHA] ? lead  : trail;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    smp       = 1'b0;
    sft       = 1'b0;
    case (state)
      IDLE: begin
        if (cs_fall) begin
          state_nxt = ACTIVE;
          start     = 1'b1;
        end
      end
      ACTIVE: begin
        smp = smp_edge;
        sft = sft_edge & ~cs_rise;
        if (cs_rise) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign complete = smp & (bit_cnt == CNT_LAST);
  assign reload   = sft & ~skip_first & reload_pend;
  assign consume  = (start | reload) & ~tx_ready_o;
  assign load_acc = tx_load_i & (tx_ready_o | consume);
  assign load_val = tx_ready_o ? TX_FILL : tx_hold;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mode_q      <= '0;
      sr          <= '0;
      bit_cnt     <= '0;
      bit_buf     <= 1'b0;
      skip_first  <= 1'b0;
      reload_pend <= 1'b0;
      tx_hold     <= '0;
      tx_ready_o  <= 1'b1;
      rx_data_bo  <= '0;
      rx_valid_o  <= 1'b0;
    end else begin
      if (start) begin
        mode_q[MODE_CPOL] <= cpol_i;
        mode_q[MODE_CPHA] <= cpha_i;
        sr                <= load_val;
        bit_cnt           <= '0;
        skip_first        <= cpha_i;
        reload_pend       <= 1'b0;
      end
      if (smp) begin
        bit_buf <= mosi_s;
        bit_cnt <= complete ? '0 : bit_cnt + 1'b1;
      end
      if (complete) begin
        reload_pend <= 1'b1;
        rx_data_bo  <= {sr[DATA_W-2:0], mosi_s};
      end
      if (sft) begin
        if (skip_first) begin
          skip_first <= 1'b0;
        end else if (reload_pend) begin
          sr          <= load_val;
          reload_pend <= 1'b0;
        end else begin
          sr <= {sr[DATA_W-2:0], bit_buf};
        end
      end
      if (load_acc) tx_hold <= tx_data_bi;
      tx_ready_o <= load_acc ? 1'b0 : (consume ? 1'b1 : tx_ready_o);
      rx_valid_o <= complete ? 1'b1 : (rx_ack_i ? 1'b0 : rx_valid_o);
    end
  end

  assign busy_o     = (state == ACTIVE);
  assign spi_miso_o = (state == ACTIVE) & sr[DATA_W-1];

`ifdef SPI_SLAVE_STATUS_EN
  logic fill_load;
  assign fill_load = (start | reload) & tx_ready_o;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rx_overrun_o  <= 1'b0;
      tx_underrun_o <= 1'b0;
    end else begin
      if (status_clr_i) begin
        rx_overrun_o  <= 1'b0;
        tx_underrun_o <= 1'b0;
      end
      if (complete && rx_valid_o) rx_overrun_o  <= 1'b1;
      if (fill_load)              tx_underrun_o <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_spi_slave_ctrl.sv
// Directed bench for spi_slave_ctrl: a bit-banged SPI master with
// hand-computed expected words for every mode and corner case.
module tb_spi_slave_ctrl;

  localparam int H = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cpol = 1'b0, cpha = 1'b0;
  logic [7:0] tx_data = '0;
  logic       tx_load = 1'b0;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ack = 1'b0;
  logic       busy;
  logic       miso;
  logic       mosi = 1'b0, sclk = 1'b0, cs = 1'b1;
`ifdef SPI_SLAVE_STATUS_EN
  logic       status_clr = 1'b0;
  logic       rx_overrun, tx_underrun;
`endif

  logic       m_cpol = 1'b0, m_cpha = 1'b0;
  logic [7:0] mi, mi2;
  logic [7:0] txw [4];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  spi_slave_ctrl #(.DATA_W(8), .SYNC_STAGES(2), .TX_FILL(8'hC3)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .cpol_i       (cpol),
    .cpha_i       (cpha),
    .tx_data_bi   (tx_data),
    .tx_load_i    (tx_load),
    .tx_ready_o   (tx_ready),
    .rx_data_bo   (rx_data),
    .rx_valid_o   (rx_valid),
    .rx_ack_i     (rx_ack),
    .busy_o       (busy),
`ifdef SPI_SLAVE_STATUS_EN
    .status_clr_i (status_clr),
    .rx_overrun_o (rx_overrun),
    .tx_underrun_o(tx_underrun),
`endif
    .spi_miso_o   (miso),
    .spi_mosi_i   (mosi),
    .spi_sclk_i   (sclk),
    .spi_cs_i     (cs)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_mode(input logic [1:0] m);
    m_cpol = m[1];
    m_cpha = m[0];
    cpol   = m[1];
    cpha   = m[0];
    sclk   = m[1];
  endtask

  task automatic load_tx(input logic [7:0] d);
    tx_data = d;
    tx_load = 1'b1;
    tick(1);
    tx_load = 1'b0;
    tick(1);
  endtask

  task automatic ack();
    rx_ack = 1'b1;
    tick(1);
    rx_ack = 1'b0;
    tick(1);
  endtask

  task automatic cs_low();
    cs = 1'b0;
    tick(H);
  endtask

  task automatic cs_high();
    cs = 1'b1;
    tick(H);
  endtask

  task automatic xfer(input logic [7:0] mo, input int nbits, output logic [7:0] mr);
    mr = '0;
    for (int i = 7; i > 7 - nbits; i--) begin
      if (!m_cpha) begin
        mosi = mo[3'(i)];
        tick(H);
        sclk = ~m_cpol;
        mr   = {mr[6:0], miso};
        tick(H);
        sclk = m_cpol;
      end else begin
        sclk = ~m_cpol;
        mosi = mo[3'(i)];
        tick(H);
        sclk = m_cpol;
        mr   = {mr[6:0], miso};
        tick(H);
      end
    end
    tick(H);
  endtask

`ifdef SPI_SLAVE_STATUS_EN
  task automatic clr_status();
    status_clr = 1'b1;
    tick(1);
    status_clr = 1'b0;
    tick(1);
  endtask
`endif

  initial begin
    txw[0] = 8'h5A; txw[1] = 8'hC6; txw[2] = 8'h39; txw[3] = 8'h7E;
    tick(3);
    check("rst_txrdy", 32'(tx_ready), 32'h1);
    check("rst_rxdata", 32'(rx_data), 32'h0);
    check("rst_rxvld", 32'(rx_valid), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_miso", 32'(miso), 32'h0);
    rst = 1'b0;
    tick(2);

    // mode 0 basic word
    set_mode(2'd0);
    tick(H);
    load_tx(8'hA5);
    check("t1_txrdy_lo", 32'(tx_ready), 32'h0);
    cs_low();
    check("t1_busy", 32'(busy), 32'h1);
    check("t1_txrdy_hi", 32'(tx_ready), 32'h1);
    check("t1_miso_b7", 32'(miso), 32'h1);
    xfer(8'h3C, 8, mi);
    check("t1_master_rx", 32'(mi), 32'hA5);
    cs_high();
    check("t1_rxdata", 32'(rx_data), 32'h3C);
    check("t1_rxvld", 32'(rx_valid), 32'h1);
    check("t1_busy_lo", 32'(busy), 32'h0);
    check("t1_miso_idle", 32'(miso), 32'h0);
    ack();
    check("t1_ack", 32'(rx_valid), 32'h0);

    // all four modes; mode inputs toggled mid-transfer must be ignored
    for (int m = 0; m < 4; m++) begin
      set_mode(2'(m));
      tick(H);
      load_tx(txw[m]);
      cs_low();
      cpol = ~m_cpol;
      cpha = ~m_cpha;
      xfer(8'h81, 8, mi);
      cs_high();
      cpol = m_cpol;
      cpha = m_cpha;
      check($sformatf("t2_rx_m%0d", m), 32'(rx_data), 32'h81);
      check($sformatf("t2_vld_m%0d", m), 32'(rx_valid), 32'h1);
      check($sformatf("t2_miso_m%0d", m), 32'(mi), 32'(txw[m]));
      ack();
    end

    // two words under one CS, TX empty for the second
    set_mode(2'd0);
    tick(H);
`ifdef SPI_SLAVE_STATUS_EN
    clr_status();
    check("t3_unrun_clr", 32'(tx_underrun), 32'h0);
`endif
    load_tx(8'hB4);
    cs_low();
    xfer(8'h12, 8, mi);
    check("t3_rx1", 32'(rx_data), 32'h12);
    check("t3_miso1", 32'(mi), 32'hB4);
    ack();
    xfer(8'h34, 8, mi2);
    cs_high();
    check("t3_rx2", 32'(rx_data), 32'h34);
    check("t3_vld2", 32'(rx_valid), 32'h1);
    check("t3_miso2_fill", 32'(mi2), 32'hC3);
`ifdef SPI_SLAVE_STATUS_EN
    check("t3_underrun", 32'(tx_underrun), 32'h1);
`endif
    ack();

    // CS raised after 5 bits; word loaded mid-frame must survive
    cs_low();
    load_tx(8'h6D);
    check("t4_txrdy_lo", 32'(tx_ready), 32'h0);
    xfer(8'hFF, 5, mi);
    cs_high();
    check("t4_no_vld", 32'(rx_valid), 32'h0);
    check("t4_busy_lo", 32'(busy), 32'h0);
    check("t4_tx_kept", 32'(tx_ready), 32'h0);
    cs_low();
    xfer(8'hF0, 8, mi);
    cs_high();
    check("t4_rx", 32'(rx_data), 32'hF0);
    check("t4_vld", 32'(rx_valid), 32'h1);
    check("t4_miso", 32'(mi), 32'h6D);
    ack();

    // ack withheld across two words
`ifdef SPI_SLAVE_STATUS_EN
    clr_status();
`endif
    cs_low();
    xfer(8'h55, 8, mi);
    cs_high();
    check("t5_rx1", 32'(rx_data), 32'h55);
`ifdef SPI_SLAVE_STATUS_EN
    check("t5_ovr_lo", 32'(rx_overrun), 32'h0);
`endif
    cs_low();
    xfer(8'hAA, 8, mi);
    cs_high();
    check("t5_rx2", 32'(rx_data), 32'hAA);
    check("t5_vld", 32'(rx_valid), 32'h1);
`ifdef SPI_SLAVE_STATUS_EN
    check("t5_ovr_hi", 32'(rx_overrun), 32'h1);
`endif

    // asynchronous reset mid-word
    load_tx(8'h52);
    cs_low();
    xfer(8'hFF, 3, mi);
    check("t6_busy_pre", 32'(busy), 32'h1);
    rst = 1'b1;
    #1;
    check("t6_txrdy", 32'(tx_ready), 32'h1);
    check("t6_rxdata", 32'(rx_data), 32'h0);
    check("t6_rxvld", 32'(rx_valid), 32'h0);
    check("t6_busy", 32'(busy), 32'h0);
    check("t6_miso", 32'(miso), 32'h0);
`ifdef SPI_SLAVE_STATUS_EN
    check("t6_ovr", 32'(rx_overrun), 32'h0);
`endif
    cs   = 1'b1;
    sclk = m_cpol;
    mosi = 1'b0;
    tick(4);
    rst = 1'b0;
    tick(H);
    load_tx(8'h99);
    cs_low();
    xfer(8'h0F, 8, mi);
    cs_high();
    check("t6_rx", 32'(rx_data), 32'h0F);
    check("t6_vld", 32'(rx_valid), 32'h1);
    check("t6_master_rx", 32'(mi), 32'h99);
    ack();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
